// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter that sequences setup/strobe/release cycles for an edge-triggered data memory.
// Define DMEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (m0 always wins a tie).
module dmem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                pick_m1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb pick_m1 = !m0_req;
`else
  logic last_grant_q, last_grant_d;

  // On a tie the master that did not win last time is served.
  always_comb pick_m1 = m1_req && (!m0_req || !last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (m0_req || m1_req)) last_grant_d = pick_m1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d     = pick_m1;
          we_d        = pick_m1 ? m1_we    : m0_we;
          mem_addr_d  = pick_m1 ? m1_addr  : m0_addr;
          mem_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        mem_write_d = we_q;
        mem_read_d  = !we_q;
        state_d     = STROBE;
      end
      STROBE: begin
        // Read data has settled since the strobe edge; capture it alongside the ack.
        if (!we_q) begin
          if (grant_q) m1_rdata_d = mem_rdata;
          else         m0_rdata_d = mem_rdata;
        end
        m0_ack_d = !grant_q;
        m1_ack_d = grant_q;
        state_d  = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural strobe-edge memory model and strobe monitor.
module tb_dmem_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [0:2047];
  int tests = 0;
  int fails = 0;
  int viol = 0;
  int ack0_cnt = 0, ack1_cnt = 0, wr_cycles = 0, rd_cycles = 0;
  logic prev_strobe = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_wdata = '0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Strobe-edge memory: data moves only on a rising read or write strobe.
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0A0A;
    mem[1] = 16'h1B1B;
    mem_rdata = '0;
    forever begin
      @(posedge mem_write or posedge mem_read);
      if (mem_write) mem[mem_addr] = mem_wdata;
      else           mem_rdata = mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) viol++;
    if ((mem_read || mem_write) && prev_strobe) viol++;
    if ((mem_read || mem_write) && (mem_addr !== prev_addr || mem_wdata !== prev_wdata)) viol++;
    prev_strobe = mem_read || mem_write;
    prev_addr   = mem_addr;
    prev_wdata  = mem_wdata;
    if (m0_ack) ack0_cnt++;
    if (m1_ack) ack1_cnt++;
    if (mem_write) wr_cycles++;
    if (mem_read) rd_cycles++;
  end

  task automatic apply_reset();
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Issues one access from an idle arbiter; returns cycles to ack (-1 on timeout) and the strobed address.
  task automatic do_access(input bit m, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, output int lat, output logic [ADDR_W-1:0] sa);
    lat = -1; sa = '0;
    if (m) begin m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1; end
    else   begin m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1; end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) sa = mem_addr;
      if ((m ? m1_ack : m0_ack) === 1'b1) begin lat = c; break; end
    end
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [ADDR_W+2*DATA_W+3:0] outs;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'h123; m0_wdata = 16'h5555;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'h456;
    repeat (3) begin @(posedge clk); #1; end
    outs = {mem_read, mem_write, m0_ack, m1_ack, mem_addr, mem_wdata, 16'h0};
    tests++;
    if (outs !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%b wr=%b a0=%b a1=%b addr=%h wd=%h r0=%h r1=%h, expected all 0",
               mem_read, mem_write, m0_ack, m1_ack, mem_addr, mem_wdata, m0_rdata, m1_rdata);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (rd_cycles + wr_cycles + ack0_cnt + ack1_cnt !== 0) begin
      fails++;
      $display("FAIL reset_idle_quiet: activity count %0d, expected 0",
               rd_cycles + wr_cycles + ack0_cnt + ack1_cnt);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [ADDR_W-1:0] sa; int wr0, a1;
    wr0 = wr_cycles; a1 = ack1_cnt;
    do_access(1'b0, 1'b1, 11'h005, 16'hBEEF, lat, sa);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d, expected 3", lat); end
    tests++;
    if (wr_cycles - wr0 !== 1) begin fails++; $display("FAIL wr_single_pulse: got %0d strobe cycles, expected 1", wr_cycles - wr0); end
    do_access(1'b0, 1'b0, 11'h005, 16'h0000, lat, sa);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d, expected 3", lat); end
    tests++;
    if (m0_rdata !== 16'hBEEF) begin fails++; $display("FAIL rd_data: got %h, expected beef", m0_rdata); end
    tests++;
    if (ack1_cnt - a1 !== 0 || m1_rdata !== 16'h0000) begin
      fails++; $display("FAIL m1_untouched: acks %0d rdata %h, expected 0 and 0000", ack1_cnt - a1, m1_rdata);
    end
  endtask

  task automatic test_round_robin();
    int who[5]; int gap[5]; int exp_who[5]; int c; int n; logic both_seen;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_who = '{0, 0, 0, 0, 1};
`else
    exp_who = '{0, 1, 0, 1, -1};
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) begin who[i] = -1; gap[i] = -1; end
    m0_we = 1'b0; m0_addr = 11'h005; m1_we = 1'b0; m1_addr = 11'h000;
    m0_req = 1'b1; m1_req = 1'b1;
    n = 0; c = 0; both_seen = 1'b0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(posedge clk); #1; c++;
      if (m0_ack && m1_ack) both_seen = 1'b1;
      if (m0_ack || m1_ack) begin who[n] = m1_ack ? 1 : 0; gap[n] = c; c = 0; n++; end
    end
    m0_req = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1; c++;
      if (m0_ack || m1_ack) begin who[4] = m1_ack ? 1 : 0; gap[4] = c; break; end
    end
`endif
    m1_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (who[i] !== exp_who[i]) begin fails++; $display("FAIL rr_grant%0d: got m%0d, expected m%0d", i, who[i], exp_who[i]); end
    end
    tests++;
    if (gap[0] !== 3 || gap[1] !== 4 || gap[3] !== 4) begin
      fails++; $display("FAIL rr_spacing: got %0d/%0d/%0d, expected 3/4/4", gap[0], gap[1], gap[3]);
    end
    tests++;
    if (both_seen !== 1'b0) begin fails++; $display("FAIL rr_single_ack: both acks high together"); end
    tests++;
    if (m0_rdata !== 16'hBEEF || m1_rdata !== 16'h0A0A) begin
      fails++; $display("FAIL rr_rdata: got %h/%h, expected beef/0a0a", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_top_address();
    int lat; logic [ADDR_W-1:0] sa;
    apply_reset();
    do_access(1'b1, 1'b1, 11'h7FF, 16'h1234, lat, sa);
    tests++;
    if (lat !== 3 || sa !== 11'h7FF) begin fails++; $display("FAIL top_write: lat %0d addr %h, expected 3 7ff", lat, sa); end
    tests++;
    if (mem[2047] !== 16'h1234 || mem[0] !== 16'h0A0A) begin
      fails++; $display("FAIL top_no_wrap: mem[7ff]=%h mem[0]=%h, expected 1234 0a0a", mem[2047], mem[0]);
    end
    do_access(1'b0, 1'b0, 11'h7FF, 16'h0000, lat, sa);
    tests++;
    if (m0_rdata !== 16'h1234 || sa !== 11'h7FF) begin fails++; $display("FAIL top_read: got %h at %h, expected 1234 at 7ff", m0_rdata, sa); end
    tests++;
    if (m1_rdata !== 16'h0000) begin fails++; $display("FAIL top_m1_rdata: got %h, expected 0000", m1_rdata); end
  endtask

  task automatic test_back_to_back();
    int c1, c2, rd0;
    c1 = -1; c2 = -1; rd0 = 0;
    m0_we = 1'b0; m0_addr = 11'h000; m0_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (m0_ack) begin c1 = c; break; end
    end
    tests++;
    if (c1 !== 3 || m0_rdata !== 16'h0A0A) begin fails++; $display("FAIL b2b_first: lat %0d data %h, expected 3 0a0a", c1, m0_rdata); end
    rd0 = rd_cycles;
    m0_addr = 11'h001;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (m0_ack) begin c2 = c; break; end
    end
    m0_req = 1'b0;
    tests++;
    if (c2 !== 4 || m0_rdata !== 16'h1B1B) begin fails++; $display("FAIL b2b_second: gap %0d data %h, expected 4 1b1b", c2, m0_rdata); end
    tests++;
    if (rd_cycles - rd0 !== 1) begin fails++; $display("FAIL b2b_strobe: got %0d read cycles, expected 1", rd_cycles - rd0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int a0; int lat; logic [ADDR_W-1:0] sa;
    m0_we = 1'b1; m0_addr = 11'h010; m0_wdata = 16'hAAAA; m0_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (mem_write !== 1'b1) begin fails++; $display("FAIL rst_strobe_seen: mem_write %b, expected 1", mem_write); end
    a0 = ack0_cnt;
    rst_n = 1'b0; m0_req = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({mem_read, mem_write, m0_ack, m1_ack} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        m0_rdata !== '0 || m1_rdata !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: rd=%b wr=%b a0=%b a1=%b addr=%h wd=%h, expected all 0",
                        mem_read, mem_write, m0_ack, m1_ack, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (ack0_cnt - a0 !== 0) begin fails++; $display("FAIL rst_no_ack: got %0d acks, expected 0", ack0_cnt - a0); end
    do_access(1'b0, 1'b0, 11'h010, 16'h0000, lat, sa);
    tests++;
    if (lat !== 3 || m0_rdata !== 16'hAAAA) begin fails++; $display("FAIL rst_landed: lat %0d data %h, expected 3 aaaa", lat, m0_rdata); end
  endtask

  task automatic test_input_freeze();
    int a0;
    a0 = ack0_cnt;
    m0_we = 1'b0; m0_addr = 11'h005; m0_req = 1'b1;
    @(posedge clk); #1;
    m0_addr = 11'h7FF;
    @(posedge clk); #1;
    tests++;
    if (mem_read !== 1'b1 || mem_addr !== 11'h005) begin
      fails++; $display("FAIL freeze_addr: rd=%b addr=%h, expected 1 005", mem_read, mem_addr);
    end
    m0_req = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (m0_ack !== 1'b1 || m0_rdata !== 16'hBEEF) begin
      fails++; $display("FAIL freeze_ack: ack=%b data=%h, expected 1 beef", m0_ack, m0_rdata);
    end
    repeat (6) begin @(posedge clk); #1; end
    tests++;
    if (ack0_cnt - a0 !== 1) begin fails++; $display("FAIL freeze_once: got %0d acks, expected 1", ack0_cnt - a0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_top_address();
    test_back_to_back();
    test_reset_mid_op();
    test_input_freeze();
    tests++;
    if (viol !== 0) begin fails++; $display("FAIL strobe_invariants: got %0d violations, expected 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
